// File: rtl/dff_serial_rx.sv
// Serial frame receiver: synchronizes a one-bit line, deframes start/data/[parity]/stop
// at one bit per clock, and hands good words to a one-entry valid/ready holding register.
module dff_serial_rx #(
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   p_bit_q, p_bit_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   s;
    logic                   parity_ok;
    logic                   frame_good;

    assign s         = sync_q[SYNC_STAGES-1];
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], in};
    assign parity_ok = (PARITY_EN == 0) || ((^shift_q ^ p_bit_q) == 1'b0);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_bit_d      = p_bit_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        frame_good   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_d[bit_cnt_q] = s;
                bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                p_bit_d = s;
                state_d = STOP;
            end
            STOP: begin
                // A broken stop bit outranks a parity mismatch.
                if (!s) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end else if (!parity_ok) begin
                    parity_err_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    frame_good = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-entry holding register; a full register only accepts a new word if it drains this edge.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (frame_good) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_bit_q      <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_bit_q      <= p_bit_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_dff_serial_rx.sv
// Directed bench: one receiver without parity (a) and one with even parity (b), table-driven
// frames plus hand-written overrun, break-line and mid-frame reset sequences.
module tb_dff_serial_rx;
    logic       clk;
    logic       rst;
    logic       in_a, in_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;
    logic       ferr_a, ferr_b;
    logic       perr_a, perr_b;
    logic       ovr_a, ovr_b;

    int checks;
    int failures;

    dff_serial_rx #(.DATA_W(8), .PARITY_EN(0), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst), .in(in_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .busy(busy_a), .frame_err(ferr_a), .parity_err(perr_a),
        .overrun(ovr_a)
    );

    dff_serial_rx #(.DATA_W(8), .PARITY_EN(1), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst(rst), .in(in_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .busy(busy_b), .frame_err(ferr_b), .parity_err(perr_b),
        .overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic sel, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) in_b = bits[i];
            else     in_a = bits[i];
            tick();
        end
    endtask

    // Sends one frame and checks outputs 1, 2 and 3 edges after the stop bit's first sampling edge.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] bits;
        int          n;
        if (v.sel) begin
            bits = {21'h0, v.stop, v.par, v.data, 1'b0};
            n    = 11;
        end else begin
            bits = {22'h0, v.stop, v.data, 1'b0};
            n    = 10;
        end
        send_bits(v.sel, bits, n);
        if (v.sel) in_b = 1'b1;
        else       in_a = 1'b1;
        tick();
        chk($sformatf("vec%0d_early_valid", idx), {15'h0, v.sel ? valid_b : valid_a}, 16'h0);
        tick();
        chk($sformatf("vec%0d_valid", idx), {15'h0, v.sel ? valid_b : valid_a}, {15'h0, v.exp_valid});
        if (v.exp_valid)
            chk($sformatf("vec%0d_data", idx), {8'h0, v.sel ? data_b : data_a}, {8'h0, v.exp_data});
        chk($sformatf("vec%0d_frame_err", idx), {15'h0, v.sel ? ferr_b : ferr_a}, {15'h0, v.exp_ferr});
        chk($sformatf("vec%0d_parity_err", idx), {15'h0, v.sel ? perr_b : perr_a}, {15'h0, v.exp_perr});
        chk($sformatf("vec%0d_overrun", idx), {15'h0, v.sel ? ovr_b : ovr_a}, 16'h0);
        tick();
        chk($sformatf("vec%0d_valid_drained", idx), {15'h0, v.sel ? valid_b : valid_a}, 16'h0);
        chk($sformatf("vec%0d_err_cleared", idx),
            {14'h0, v.sel ? ferr_b : ferr_a, v.sel ? perr_b : perr_a}, 16'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_a     = 1'b1;
        in_b     = 1'b1;
        ready_a  = 1'b0;
        ready_b  = 1'b0;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a", {data_a, 3'b0, valid_a, busy_a, ferr_a, perr_a, ovr_a}, 16'h0);
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_outputs_a", {data_a, 3'b0, valid_a, busy_a, ferr_a, perr_a, ovr_a}, 16'h0);
        chk("idle_outputs_b", {data_b, 3'b0, valid_b, busy_b, ferr_b, perr_b, ovr_b}, 16'h0);

        ready_a = 1'b1;
        ready_b = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-to-back 0x3C then 0xFF with the consumer stalled.
        ready_a = 1'b0;
        send_bits(1'b0, {12'h0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0}, 12);
        chk("b2b_first_valid", {15'h0, valid_a}, 16'h1);
        chk("b2b_first_data", {8'h0, data_a}, 16'h003C);
        send_bits(1'b0, {24'h0, 1'b1, 7'h7F}, 8);
        in_a = 1'b1;
        tick();
        chk("b2b_no_early_overrun", {15'h0, ovr_a}, 16'h0);
        tick();
        chk("b2b_overrun", {15'h0, ovr_a}, 16'h1);
        chk("b2b_data_held", {8'h0, data_a}, 16'h003C);
        chk("b2b_still_valid", {15'h0, valid_a}, 16'h1);
        tick();
        chk("b2b_overrun_one_cycle", {15'h0, ovr_a}, 16'h0);
        chk("b2b_valid_before_ready", {15'h0, valid_a}, 16'h1);
        ready_a = 1'b1;
        tick();
        chk("b2b_drained", {15'h0, valid_a}, 16'h0);

        // 0x81 with a zero stop bit followed by three more zero clocks.
        send_bits(1'b0, {22'h0, 1'b0, 8'h81, 1'b0}, 10);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("brk_ferr_k%0d", k), {15'h0, ferr_a}, (k == 2) ? 16'h1 : 16'h0);
            chk($sformatf("brk_busy_k%0d", k), {15'h0, busy_a}, 16'h1);
            chk($sformatf("brk_valid_k%0d", k), {15'h0, valid_a}, 16'h0);
        end
        in_a = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk($sformatf("brk_busy_k%0d", k), {15'h0, busy_a}, (k == 6) ? 16'h0 : 16'h1);
            chk($sformatf("brk_ferr_k%0d", k), {15'h0, ferr_a}, 16'h0);
        end
        run_vec(10, '{1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0});

        // Hold a word, then reset in the middle of the next frame.
        ready_a = 1'b0;
        send_bits(1'b0, {22'h0, 1'b1, 8'h11, 1'b0}, 10);
        in_a = 1'b1;
        tick();
        tick();
        chk("pre_rst_held_valid", {15'h0, valid_a}, 16'h1);
        chk("pre_rst_held_data", {8'h0, data_a}, 16'h0011);
        send_bits(1'b0, {23'h0, 9'h12C}, 5);
        chk("pre_rst_busy", {15'h0, busy_a}, 16'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {data_a, 3'b0, valid_a, busy_a, ferr_a, perr_a, ovr_a}, 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        in_a    = 1'b1;
        ready_a = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {data_a, 3'b0, valid_a, busy_a, ferr_a, perr_a, ovr_a}, 16'h0);
        run_vec(11, '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
